pe_out_buff: RTL
================

// Module: pe_out_buff
// PURPOSE
//  Output result buffer directly downstream of the PE array/controller. Captures one
//  signed PE result per cycle while the controller's out_en is high, raises buff_full
//  as back-pressure, and drains stored results to post-processing (pp) as a
//  valid/ready write-back burst. A burst starts when the buffer fills or on force_wb.
// PARAMETERS
//  DATA_W   16  width of one PE result word (signed, two's complement)
//  DEPTH     8  buffer entries; power of two, >= 2
//  CNT_W     $clog2(DEPTH+1)  occupancy counter width (derived, not overridden)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  out_en     in   1        PE result valid (one word per cycle)
//  pe_data    in   DATA_W   PE result word, sampled when out_en=1
//  force_wb   in   1        pulse: write back partial contents now
//  buff_full  out  1        occupancy == DEPTH (to PE controller)
//  wb_valid   out  1        write-back word valid
//  wb_ready   in   1        pp accepts word when wb_valid & wb_ready
//  wb_data    out  DATA_W   write-back word (head of buffer)
//  wb_last    out  1        final word of current burst
//  wb_done    out  1        1-cycle pulse the cycle after the last word is accepted
//  ovf_err    out  1        sticky: a word arrived while full and was dropped
// BEHAVIOUR
//  - Reset (async): all outputs 0; wr_ptr=rd_ptr=0; count=0; burst_left=0; state IDLE.
//  - Storage: circular, wr_ptr/rd_ptr wrap DEPTH-1 -> 0. push = out_en & (count<DEPTH | pop).
//    pop = wb_valid & wb_ready. Simultaneous push+pop: count unchanged, both pointers advance.
//  - out_en while count==DEPTH and no pop: word dropped, ovf_err set until reset.
//  - buff_full is registered: high the cycle after count reaches DEPTH; low the cycle after
//    count drops below DEPTH.
//  - FSM states IDLE, DRAIN:
//    IDLE -> DRAIN when count==DEPTH, or force_wb=1 and count>0; burst_left <= count
//      (words pushed in that same cycle are not part of this burst).
//    force_wb with count==0: ignored, no burst, no wb_done.
//    force_wb during DRAIN: ignored.
//    DRAIN: wb_valid=1, wb_data=mem[rd_ptr] (first word valid the cycle after the trigger).
//      On each pop burst_left decrements; wb_last = (burst_left==1).
//      Last pop -> IDLE; wb_done=1 for one cycle. New trigger is evaluated in that IDLE cycle.
//  - wb_valid stays high and wb_data stable while wb_ready=0 (no retraction).
//  - Pushes continue during DRAIN; words beyond burst_left wait for the next burst.
//  - Reset mid-burst: burst aborted, buffer contents discarded.
// CONFIGURATION
//  - OBUF_RELU_EN defined: wb_data = (mem[rd_ptr] < 0) ? 0 : mem[rd_ptr]; applied on the
//    read side only, stored words are unmodified.
//  - Not defined: wb_data = mem[rd_ptr] unchanged (signed pass-through).
// STRUCTURE
//  - def.v (shared): state encodings OBUF_IDLE/OBUF_DRAIN, default DATA_W/DEPTH defines.
//  - Sub-module obuf_mem: DEPTH x DATA_W register file, 1 write port, async read port.
//  - Top: pointers, counter, FSM, burst counter, ReLU mux, error flag.
// TESTING
//  1. Reset, then 8 out_en words 1..8, wb_ready=0 -> buff_full=1 from cycle 9;
//     wb_valid=1, wb_data=1, held stable.
//  2. Continue 1: wb_ready=1 -> words 1..8 in order on 8 consecutive cycles, wb_last on 8,
//     wb_done the next cycle, buff_full low after the first pop.
//  3. Push 3 words (-5,7,-2), force_wb -> burst of 3, wb_last on -2; with OBUF_RELU_EN the
//     output is 0,7,0.
//  4. Full buffer, out_en=1 with wb_ready=0 -> ovf_err=1, dropped word never appears;
//     simultaneous push+pop keeps count=DEPTH and accepts the word.
//  5. force_wb with empty buffer -> no wb_valid, no wb_done; force_wb during DRAIN ignored.
//  6. Assert reset after 2 of 8 words are drained -> all outputs 0 immediately; a new 1-word
//     force_wb burst after reset returns the new word.

Source files
------------

// File: rtl/pe_out_buff_pkg.sv
// -----------------------------------------------------------------------------
// pe_out_buff_pkg
// Purpose : shared constants for the PE output buffer slice.
//           - default geometry (data width, buffer depth)
//           - write-back FSM state encodings (legacy-compatible constants)
// Ports   : none (package)
// -----------------------------------------------------------------------------
package pe_out_buff_pkg;

   localparam int OBUF_DATA_W = 16;
   localparam int OBUF_DEPTH  = 8;

   localparam logic [0:0] OBUF_IDLE  = 1'b0;
   localparam logic [0:0] OBUF_DRAIN = 1'b1;

endpackage

// File: rtl/pe_out_buff_mem.sv
// -----------------------------------------------------------------------------
// pe_out_buff_mem
// Purpose : DEPTH x DATA_W register file with one synchronous write port and
//           one asynchronous read port. Cleared on reset so that a burst
//           aborted by reset leaves no stale words behind.
// Ports   :
//   clk    in   1       clock, rising edge
//   reset  in   1       asynchronous, active-high
//   we     in   1       write enable
//   waddr  in   PTR_W   write address
//   wdata  in   DATA_W  write data
//   raddr  in   PTR_W   read address
//   rdata  out  DATA_W  read data (combinational)
// -----------------------------------------------------------------------------
module pe_out_buff_mem
   import pe_out_buff_pkg::*;
#(
   parameter int DATA_W = OBUF_DATA_W,
   parameter int DEPTH  = OBUF_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [0:DEPTH-1];

   // Storage array: cleared on reset, one word written per enabled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Asynchronous read of the addressed word.
   always_comb begin
      rdata = mem_r[raddr];
   end

endmodule

// File: rtl/pe_out_buff.sv
// -----------------------------------------------------------------------------
// pe_out_buff
// Purpose : output result buffer downstream of the PE array. Captures one
//           signed PE result per cycle while out_en is high, signals
//           back-pressure with buff_full, and drains stored words to
//           post-processing as a valid/ready write-back burst. A burst starts
//           when the buffer is full or on a force_wb pulse with data present.
// Config  : OBUF_RELU_EN - when defined, negative words are replaced by zero
//           on the read side (stored words are never modified). Default build
//           passes words through unchanged.
// Ports   :
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high
//   out_en     in   1       PE result valid
//   pe_data    in   DATA_W  PE result word
//   force_wb   in   1       write back partial contents now
//   buff_full  out  1       occupancy == DEPTH (registered)
//   wb_valid   out  1       write-back word valid
//   wb_ready   in   1       post-processing accepts the word
//   wb_data    out  DATA_W  write-back word (head of buffer)
//   wb_last    out  1       final word of the current burst
//   wb_done    out  1       pulse the cycle after the last word is accepted
//   ovf_err    out  1       sticky: a word arrived while full and was dropped
// -----------------------------------------------------------------------------
module pe_out_buff
   import pe_out_buff_pkg::*;
#(
   parameter int DATA_W = OBUF_DATA_W,
   parameter int DEPTH  = OBUF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              out_en,
   input  logic [DATA_W-1:0] pe_data,
   input  logic              force_wb,
   output logic              buff_full,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_last,
   output logic              wb_done,
   output logic              ovf_err
);

   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [0:0]        state_r;
   logic [0:0]        state_next_s;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic [CNT_W-1:0]  burst_left_r;
   logic [CNT_W-1:0]  burst_left_next_s;
   logic              buff_full_r;
   logic              wb_done_r;
   logic              wb_done_next_s;
   logic              ovf_err_r;
   logic              draining_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic              drop_s;
   logic              trigger_s;
   logic [DATA_W-1:0] rd_word_s;

   // Pointer advance with explicit wrap from the last entry back to zero.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_ONE;
      end
   endfunction

   // Clamp negative two's complement words to zero.
   function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] w);
      if (w[DATA_W-1]) begin
         return {DATA_W{1'b0}};
      end else begin
         return w;
      end
   endfunction

   pe_out_buff_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (push_s),
      .waddr (wr_ptr_r),
      .wdata (pe_data),
      .raddr (rd_ptr_r),
      .rdata (rd_word_s)
   );

   // Handshake qualifiers. A push into a full buffer is allowed only when the
   // head word leaves in the same cycle, keeping occupancy at DEPTH.
   always_comb begin
      draining_s = (state_r == OBUF_DRAIN);
      full_s     = (count_r == DEPTH_C);
      pop_s      = draining_s & wb_ready;
      push_s     = out_en & (~full_s | pop_s);
      drop_s     = out_en & full_s & ~pop_s;
      // Trigger looks at the registered count, so words pushed this cycle
      // wait for a later burst.
      trigger_s  = ~draining_s & (full_s | (force_wb & (count_r != CNT_ZERO)));
   end

   // Occupancy update from the push/pop pair.
   always_comb begin
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // Write-back FSM next state, burst length bookkeeping and done pulse.
   always_comb begin
      state_next_s      = state_r;
      burst_left_next_s = burst_left_r;
      wb_done_next_s    = 1'b0;
      case (state_r)
         OBUF_IDLE: begin
            if (trigger_s) begin
               state_next_s      = OBUF_DRAIN;
               burst_left_next_s = count_r;
            end else begin
               state_next_s      = OBUF_IDLE;
            end
         end
         OBUF_DRAIN: begin
            if (pop_s) begin
               burst_left_next_s = burst_left_r - CNT_ONE;
               if (burst_left_r == CNT_ONE) begin
                  state_next_s   = OBUF_IDLE;
                  wb_done_next_s = 1'b1;
               end else begin
                  state_next_s   = OBUF_DRAIN;
               end
            end else begin
               state_next_s = OBUF_DRAIN;
            end
         end
         default: begin
            state_next_s      = OBUF_IDLE;
            burst_left_next_s = CNT_ZERO;
         end
      endcase
   end

   // Pointers, occupancy and FSM registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= OBUF_IDLE;
         wr_ptr_r     <= {PTR_W{1'b0}};
         rd_ptr_r     <= {PTR_W{1'b0}};
         count_r      <= CNT_ZERO;
         burst_left_r <= CNT_ZERO;
      end else begin
         state_r      <= state_next_s;
         count_r      <= count_next_s;
         burst_left_r <= burst_left_next_s;
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
      end
   end

   // Registered status outputs: full flag, done pulse and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buff_full_r <= 1'b0;
         wb_done_r   <= 1'b0;
         ovf_err_r   <= 1'b0;
      end else begin
         buff_full_r <= (count_next_s == DEPTH_C);
         wb_done_r   <= wb_done_next_s;
         if (drop_s) begin
            ovf_err_r <= 1'b1;
         end
      end
   end

   // Write-back data path. Outside a burst the data bus is held at zero so the
   // buffer head never leaks onto the interface.
   always_comb begin
      wb_valid = draining_s;
      wb_last  = draining_s & (burst_left_r == CNT_ONE);
      if (draining_s) begin
`ifdef OBUF_RELU_EN
         wb_data = relu(rd_word_s);
`else
         wb_data = rd_word_s;
`endif
      end else begin
         wb_data = {DATA_W{1'b0}};
      end
      buff_full = buff_full_r;
      wb_done   = wb_done_r;
      ovf_err   = ovf_err_r;
   end

endmodule
